// File: rtl/jt6295_chseq.sv
// jt6295_chseq: four-slot time-multiplexed ADPCM nibble address sequencer.
// Each slot fetches at most one ROM byte for its channel and emits one nibble.
`default_nettype none

module jt6295_chseq #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen4,
  input  logic          cen1,
  input  logic [3:0]    start,
  input  logic [3:0]    stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stop_addr,
  input  logic [3:0]    att,
  output logic [3:0]    busy,
  output logic          zero,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    nibble,
  output logic [1:0]    nibble_ch,
  output logic [3:0]    nibble_att,
  output logic          nibble_valid,
  output logic          nibble_miss,
  output logic [3:0]    ch_end
);

  logic [1:0]    slot_q, slot_d, fch_q, fch_d, nib_ch_q, nib_ch_d;
  logic [3:0]    start_q, start_d, pending_q, pending_d, busy_q, busy_d;
  logic [AW:0]   ptr_q [4];
  logic [AW:0]   ptr_d [4];
  logic [AW-1:0] end_q [4];
  logic [AW-1:0] end_d [4];
  logic [3:0]    att_q [4];
  logic [3:0]    att_d [4];
  logic          zero_q, zero_d, rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]    nib_q, nib_d, nib_att_q, nib_att_d, ch_end_q, ch_end_d;
  logic          nib_valid_q, nib_valid_d, nib_miss_q, nib_miss_d;

  logic [3:0]    pend;
  logic [1:0]    slot_nx;
  logic          load;

  always_comb begin
    slot_d      = slot_q;
    start_d     = start;
    pend        = pending_q | (start & ~start_q);
    pending_d   = pend;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    att_d       = att_q;
    fch_d       = fch_q;
    zero_d      = 1'b0;
    rom_cs_d    = rom_cs_q;
    rom_addr_d  = rom_addr_q;
    nib_d       = nib_q;
    nib_ch_d    = nib_ch_q;
    nib_att_d   = nib_att_q;
    nib_valid_d = 1'b0;
    nib_miss_d  = 1'b0;
    ch_end_d    = 4'b0000;
    slot_nx     = slot_q + 2'd1;
    load        = 1'b0;

    // A slot advance always wins over a ROM answer arriving in the same clk
    if (rom_cs_q) begin
      if (cen4) begin
        rom_cs_d   = 1'b0;
        nib_miss_d = 1'b1;
      end else if (rom_ok) begin
        rom_cs_d    = 1'b0;
        nib_valid_d = 1'b1;
        nib_ch_d    = fch_q;
        nib_att_d   = att_q[fch_q];
        nib_d       = ptr_q[fch_q][0] ? rom_data[3:0] : rom_data[7:4];
        ptr_d[fch_q] = ptr_q[fch_q] + 1'b1;
        if (ptr_q[fch_q][0] && (ptr_q[fch_q][AW:1] == end_q[fch_q])) begin
          busy_d[fch_q]   = 1'b0;
          ch_end_d[fch_q] = 1'b1;
        end
      end
    end

    if (cen4) begin
      slot_d = slot_nx;
      zero_d = (slot_q == 2'd3);
      if (stop[slot_nx]) begin
        busy_d[slot_nx]    = 1'b0;
        pending_d[slot_nx] = 1'b0;
      end else begin
        if (pend[slot_nx] && !busy_q[slot_nx]) begin
          load             = 1'b1;
          ptr_d[slot_nx]   = {start_addr, 1'b0};
          end_d[slot_nx]   = stop_addr;
          att_d[slot_nx]   = att;
          busy_d[slot_nx]  = 1'b1;
        end
        pending_d[slot_nx] = 1'b0;
        if (load || busy_q[slot_nx]) begin
          rom_cs_d   = 1'b1;
          fch_d      = slot_nx;
          rom_addr_d = load ? start_addr : ptr_q[slot_nx][AW:1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= 2'd0;
      start_q     <= 4'd0;
      pending_q   <= 4'd0;
      busy_q      <= 4'd0;
      fch_q       <= 2'd0;
      zero_q      <= 1'b0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
      nib_q       <= 4'd0;
      nib_ch_q    <= 2'd0;
      nib_att_q   <= 4'd0;
      nib_valid_q <= 1'b0;
      nib_miss_q  <= 1'b0;
      ch_end_q    <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        ptr_q[k] <= '0;
        end_q[k] <= '0;
        att_q[k] <= 4'd0;
      end
    end else begin
      slot_q      <= slot_d;
      start_q     <= start_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
      fch_q       <= fch_d;
      zero_q      <= zero_d;
      rom_cs_q    <= rom_cs_d;
      rom_addr_q  <= rom_addr_d;
      nib_q       <= nib_d;
      nib_ch_q    <= nib_ch_d;
      nib_att_q   <= nib_att_d;
      nib_valid_q <= nib_valid_d;
      nib_miss_q  <= nib_miss_d;
      ch_end_q    <= ch_end_d;
      for (int k = 0; k < 4; k++) begin
        ptr_q[k] <= ptr_d[k];
        end_q[k] <= end_d[k];
        att_q[k] <= att_d[k];
      end
    end
  end

  assign busy         = busy_q;
  assign zero         = zero_q;
  assign rom_addr     = rom_addr_q;
  assign rom_cs       = rom_cs_q;
  assign nibble       = nib_q;
  assign nibble_ch    = nib_ch_q;
  assign nibble_att   = nib_att_q;
  assign nibble_valid = nib_valid_q;
  assign nibble_miss  = nib_miss_q;
  assign ch_end       = ch_end_q;

  a_cen1_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    cen1 |-> (cen4 && slot_q == 2'd3));

endmodule

`default_nettype wire

// File: tb/tb_jt6295_chseq.sv
// Randomized self-checking bench for jt6295_chseq against a slot-level channel model.
`default_nettype none

module tb_jt6295_chseq;
  localparam int AW    = 18;
  localparam int L     = 8;
  localparam int NEVER = 99;

  logic          clk = 1'b0, rst_n = 1'b0, cen4 = 1'b0, cen1 = 1'b0;
  logic [3:0]    start = 4'd0, stop = 4'd0, att = 4'd0;
  logic [AW-1:0] start_addr = '0, stop_addr = '0;
  logic [3:0]    busy, nibble, nibble_att, ch_end;
  logic          zero, rom_cs, rom_ok, nibble_valid, nibble_miss;
  logic [1:0]    nibble_ch;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  logic [7:0] mem [1024];
  int rom_lat = NEVER;
  int rom_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_cnt <= (!rom_cs || cen4) ? 0 : rom_cnt + 1;
  assign rom_ok   = rom_cs && (rom_cnt >= rom_lat);
  assign rom_data = mem[rom_addr[9:0]];

  jt6295_chseq #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cen4(cen4), .cen1(cen1), .start(start), .stop(stop),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .busy(busy), .zero(zero),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .nibble(nibble), .nibble_ch(nibble_ch), .nibble_att(nibble_att),
    .nibble_valid(nibble_valid), .nibble_miss(nibble_miss), .ch_end(ch_end)
  );

  // Reference model: per-channel nibble pointer, end byte, attenuation, flags
  int            mslot;
  logic [AW:0]   mptr [4];
  logic [AW-1:0] mend [4];
  logic [3:0]    matt [4];
  logic [3:0]    mbusy, mpend;
  bit            carry_miss;

  int            nvalid [4];
  int            nend [4];
  int            nmiss = 0, nzero = 0;
  logic [AW-1:0] last_addr [4];
  logic [3:0]    seen [$];
  int            nrun = 0, nfail = 0;

  task automatic model_reset();
    mslot = 0; mbusy = 4'd0; mpend = 4'd0; carry_miss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mptr[i] = '0; mend[i] = '0; matt[i] = 4'd0;
    end
  endtask

  // One full slot: cen4 edge, then L-1 observed clks. Model decides entry and fetch outcome.
  task automatic do_slot(input int lat, input logic [3:0] sbits, input logic [3:0] stop_set,
                         input int rst_at);
    int c, okj;
    bit fetch, ezero, eend;
    logic [AW:0] p;
    logic [7:0]  b;
    logic [3:0]  en, eendv;
    cen4 = 1'b1; cen1 = (mslot == 3);
    @(posedge clk); #1;
    cen4 = 1'b0; cen1 = 1'b0; rom_lat = lat;
    c = (mslot + 1) % 4; ezero = (mslot == 3); mslot = c;
    fetch = 1'b0;
    if (stop[c]) begin
      mbusy[c] = 1'b0; mpend[c] = 1'b0;
    end else begin
      if (mpend[c] && !mbusy[c]) begin
        mptr[c] = {start_addr, 1'b0}; mend[c] = stop_addr; matt[c] = att; mbusy[c] = 1'b1;
      end
      mpend[c] = 1'b0;
      fetch = mbusy[c];
    end
    if (zero) nzero++;
    if (nibble_miss) nmiss++;
    nrun++;
    if ({zero, nibble_miss, nibble_valid, rom_cs, busy} !== {ezero, carry_miss, 1'b0, fetch, mbusy}) begin
      nfail++;
      $display("FAIL slot_entry ch%0d: zero/miss/valid/cs/busy got %b exp %b", c,
               {zero, nibble_miss, nibble_valid, rom_cs, busy}, {ezero, carry_miss, 1'b0, fetch, mbusy});
    end
    if (fetch) begin
      last_addr[c] = rom_addr;
      nrun++;
      if (rom_addr !== mptr[c][AW:1]) begin
        nfail++;
        $display("FAIL rom_addr ch%0d: got %h exp %h", c, rom_addr, mptr[c][AW:1]);
      end
    end
    p  = mptr[c];
    b  = mem[p[10:1]];
    en = p[0] ? (b & 8'h0F) : (b >> 4);
    eend  = p[0] && (p[AW:1] == mend[c]);
    eendv = eend ? (4'b0001 << c) : 4'b0000;
    okj = (fetch && lat <= L - 2) ? lat + 1 : -1;
    carry_miss = fetch && (okj < 0);
    for (int j = 1; j < L; j++) begin
      if (j == 1) stop = stop | stop_set;
      if (j == 2 && sbits != 4'd0) begin start = sbits; mpend = mpend | sbits; end
      if (j == 4) start = 4'd0;
      if (j == rst_at) begin
        rst_n = 1'b0; #1;
        nrun++;
        if ({busy, zero, rom_addr, rom_cs, nibble, nibble_ch, nibble_att, nibble_valid,
             nibble_miss, ch_end} !== '0) begin
          nfail++;
          $display("FAIL reset_outputs: busy=%b cs=%b addr=%h valid=%b got nonzero exp 0",
                   busy, rom_cs, rom_addr, nibble_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; start = 4'd0;
        model_reset();
        return;
      end
      @(posedge clk); #1;
      if (zero) nzero++;
      if (nibble_miss) nmiss++;
      if (nibble_valid) begin
        nvalid[nibble_ch]++;
        if (nibble_ch == 2'd0) seen.push_back(nibble);
      end
      for (int i = 0; i < 4; i++) if (ch_end[i]) nend[i]++;
      nrun++;
      if (nibble_valid !== (j == okj)) begin
        nfail++;
        $display("FAIL nibble_valid ch%0d clk%0d: got %b exp %b", c, j, nibble_valid, j == okj);
      end
      if (j == okj) begin
        mptr[c] = mptr[c] + 1'b1;
        if (eend) mbusy[c] = 1'b0;
        nrun++;
        if ({nibble, nibble_ch, nibble_att, ch_end, busy} !== {en, c[1:0], matt[c], eendv, mbusy}) begin
          nfail++;
          $display("FAIL nibble ch%0d: nib/ch/att/end/busy got %h %0d %h %b %b exp %h %0d %h %b %b",
                   c, nibble, nibble_ch, nibble_att, ch_end, busy, en, c, matt[c], eendv, mbusy);
        end
      end else begin
        nrun++;
        if ({ch_end, nibble_miss, zero} !== 6'd0) begin
          nfail++;
          $display("FAIL idle_strobes ch%0d clk%0d: end/miss/zero got %b exp 0", c, j,
                   {ch_end, nibble_miss, zero});
        end
      end
      if (j == L - 1) begin
        nrun++;
        if ({busy, rom_cs} !== {mbusy, fetch && (lat >= L - 1)}) begin
          nfail++;
          $display("FAIL slot_tail ch%0d: busy/cs got %b exp %b", c, {busy, rom_cs},
                   {mbusy, fetch && (lat >= L - 1)});
        end
      end
    end
  endtask

  task automatic launch(input int ch, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                        input logic [3:0] a);
    int k;
    start_addr = sa; stop_addr = ea; att = a;
    do_slot(2, 4'b0001 << ch, 4'd0, -1);
    k = 0;
    while (!mbusy[ch] && k < 6) begin
      do_slot(2, 4'd0, 4'd0, -1);
      k++;
    end
    nrun++;
    if (!mbusy[ch] || busy[ch] !== 1'b1) begin
      nfail++;
      $display("FAIL launch ch%0d: busy got %b exp 1 within 6 slots", ch, busy[ch]);
    end
  endtask

  task automatic goto_slot(input int ch);
    while ((mslot + 1) % 4 != ch) do_slot(2, 4'd0, 4'd0, -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrun++;
    if ({busy, zero, rom_addr, rom_cs, nibble, nibble_ch, nibble_att, nibble_valid,
         nibble_miss, ch_end} !== '0) begin
      nfail++;
      $display("FAIL reset_state: busy=%b cs=%b addr=%h exp all 0", busy, rom_cs, rom_addr);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_phrase();
    int e0;
    mem[10'h100] = 8'hA3; mem[10'h101] = 8'h7C;
    seen.delete(); e0 = nend[0];
    launch(0, 18'h00100, 18'h00101, 4'd5);
    repeat (16) do_slot(2, 4'd0, 4'd0, -1);
    nrun++;
    if (seen.size() != 4 || {seen[0], seen[1], seen[2], seen[3]} !== 16'hA37C) begin
      nfail++;
      $display("FAIL phrase_seq: got %0d nibbles exp A37C", seen.size());
    end
    nrun++;
    if (nend[0] - e0 != 1 || busy[0] !== 1'b0) begin
      nfail++;
      $display("FAIL phrase_end: ch_end count %0d busy %b exp 1 and 0", nend[0] - e0, busy[0]);
    end
  endtask

  task automatic test_two_channels();
    int v[4];
    int z;
    launch(0, 18'h00200, 18'h00203, 4'd3);
    launch(2, 18'h00220, 18'h00227, 4'd9);
    nrun++;
    if (busy !== 4'b0101) begin
      nfail++;
      $display("FAIL two_busy: got %b exp 0101", busy);
    end
    for (int i = 0; i < 4; i++) v[i] = nvalid[i];
    z = nzero;
    repeat (8) do_slot($urandom_range(0, L - 2), 4'd0, 4'd0, -1);
    nrun++;
    if (nvalid[0] - v[0] != 2 || nvalid[2] - v[2] != 2 || nvalid[1] != v[1] || nvalid[3] != v[3]
        || nzero - z != 2) begin
      nfail++;
      $display("FAIL two_slots: valids %0d %0d %0d %0d zeros %0d exp 2 0 2 0 zeros 2",
               nvalid[0] - v[0], nvalid[1] - v[1], nvalid[2] - v[2], nvalid[3] - v[3], nzero - z);
    end
  endtask

  task automatic test_ignored_start();
    launch(1, 18'h00300, 18'h0030F, 4'd4);
    start_addr = 18'h00380; stop_addr = 18'h00381;
    do_slot(2, 4'b0010, 4'd0, -1);
    repeat (8) do_slot(2, 4'd0, 4'd0, -1);
    nrun++;
    if (busy[1] !== 1'b1 || last_addr[1] < 18'h00300 || last_addr[1] > 18'h0030F) begin
      nfail++;
      $display("FAIL ignored_start: busy %b addr %h exp 1 and 300..30F", busy[1], last_addr[1]);
    end
  endtask

  task automatic test_stop_inflight();
    int e, v;
    launch(3, 18'h00400, 18'h0040F, 4'd7);
    goto_slot(3);
    e = nend[3]; v = nvalid[3];
    do_slot(4, 4'd0, 4'b1000, -1);
    repeat (4) do_slot(2, 4'd0, 4'd0, -1);
    nrun++;
    if (nvalid[3] - v != 1 || nend[3] != e || busy[3] !== 1'b0) begin
      nfail++;
      $display("FAIL stop_inflight: nibbles %0d ends %0d busy %b exp 1 0 0",
               nvalid[3] - v, nend[3] - e, busy[3]);
    end
    stop = 4'd0;
  endtask

  task automatic test_miss();
    int lats[2];
    int m, v;
    logic [AW-1:0] a;
    lats[0] = NEVER; lats[1] = L - 1;
    for (int t = 0; t < 2; t++) begin
      goto_slot(1);
      m = nmiss; v = nvalid[1];
      do_slot(lats[t], 4'd0, 4'd0, -1);
      a = last_addr[1];
      goto_slot(1);
      do_slot(2, 4'd0, 4'd0, -1);
      nrun++;
      if (nmiss - m != 1 || nvalid[1] - v != 1 || last_addr[1] !== a) begin
        nfail++;
        $display("FAIL late_rom lat%0d: misses %0d nibbles %0d addr %h exp 1 1 %h",
                 lats[t], nmiss - m, nvalid[1] - v, last_addr[1], a);
      end
    end
  endtask

  task automatic test_mid_reset();
    int v;
    launch(2, 18'h00600, 18'h0060F, 4'd2);
    goto_slot(2);
    do_slot(NEVER, 4'd0, 4'd0, 2);
    v = nvalid[0] + nvalid[1] + nvalid[2] + nvalid[3];
    repeat (8) do_slot(1, 4'd0, 4'd0, -1);
    nrun++;
    if (busy !== 4'd0 || nvalid[0] + nvalid[1] + nvalid[2] + nvalid[3] != v) begin
      nfail++;
      $display("FAIL after_reset: busy %b new nibbles %0d exp 0 0", busy,
               nvalid[0] + nvalid[1] + nvalid[2] + nvalid[3] - v);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [3:0] sb;
    for (int n = 0; n < 240; n++) begin
      start_addr = AW'($urandom_range(0, 1000));
      stop_addr  = start_addr + AW'($urandom_range(0, 3));
      att        = 4'($urandom);
      if ($urandom_range(0, 15) == 0) stop = 4'($urandom) & 4'($urandom);
      else if ($urandom_range(0, 3) == 0) stop = 4'd0;
      lat = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, L);
      sb  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      do_slot(lat, sb, 4'd0, -1);
    end
    stop = 4'd0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin nvalid[i] = 0; nend[i] = 0; last_addr[i] = '0; end
    model_reset();
    test_reset();
    test_single_phrase();
    test_two_channels();
    test_ignored_start();
    test_stop_inflight();
    test_miss();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

`default_nettype wire
